// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: MEM-stage request/response bus between the core and the data RAM responder.
interface data_memory_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_err, stall
    );
endinterface

// File: rtl/data_memory_responder.sv
// data_memory_responder: multi-cycle data RAM responder with wait states and a pipeline stall output.
// Define DMEM_MISALIGN_CHECK_EN to reject accesses with req_addr[1:0] != 0 via resp_err.
module data_memory_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input logic                   clk,
    input logic                   rst,
    data_memory_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
    state_t            state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic              wr_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [31:0]       rdata_q;
    logic              mis_q;
    logic              unused_addr;
    logic [31:0]       mem [2**ADDR_W];
    wire               accept = state == IDLE && bus.req_valid;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: if (bus.req_valid) begin
                if (WAIT_STATES > 0) begin
                    state_d = WAIT;
                    cnt_d   = 4'(WAIT_STATES - 1);
                end else
                    state_d = ACCESS;
            end
            WAIT: if (cnt == '0) state_d = ACCESS;
                  else cnt_d = cnt - 4'd1;
            ACCESS: state_d = RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                wr_q    <= bus.req_write;
                idx_q   <= bus.req_addr[ADDR_W+1:2];
                wdata_q <= bus.req_wdata;
                be_q    <= bus.req_be;
            end
            if (state == ACCESS) rdata_q <= mis_q ? '0 : mem[idx_q];
        end
    // RAM has no reset; a store only commits in ACCESS, so an aborted store never lands
    always_ff @(posedge clk)
        if (state == ACCESS && wr_q && !mis_q)
            for (int i = 0; i < 4; i++)
                if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
`ifdef DMEM_MISALIGN_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            mis_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (accept) mis_q <= |bus.req_addr[1:0];
            if (state == ACCESS) err_q <= mis_q;
        end
    assign bus.resp_err = err_q;
    assign unused_addr  = ^bus.req_addr[31:ADDR_W+2];
`else
    assign mis_q        = 1'b0;
    assign bus.resp_err = 1'b0;
    assign unused_addr  = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0]};
`endif
    assign bus.req_ready  = state == IDLE;
    assign bus.resp_valid = state == RESP;
    assign bus.resp_rdata = rdata_q;
    assign bus.stall      = accept || state == WAIT || state == ACCESS;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed self-checking bench for data_memory_responder (ADDR_W=8, WAIT_STATES=2).
module tb_data_memory_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   r_lat;
    logic [31:0] r_data;
    logic r_err, r_bad, r_pulse, flag;
    data_memory_responder_if bus ();
    data_memory_responder #(.ADDR_W(8), .WAIT_STATES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d; bus.req_be = b;
        #1 r_bad = (bus.req_ready !== 1'b1 || bus.stall !== 1'b1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0; bus.req_write = ~w; bus.req_addr = $urandom;
        bus.req_wdata = $urandom; bus.req_be = 4'($urandom);
        r_lat = 0;
        do begin
            @(negedge clk);
            r_lat++;
            if (bus.resp_valid !== 1'b1 && (bus.stall !== 1'b1 || bus.req_ready !== 1'b0)) r_bad = 1'b1;
        end while (bus.resp_valid !== 1'b1 && r_lat < 40);
        r_data = bus.resp_rdata;
        r_err  = bus.resp_err;
        if (bus.stall !== 1'b0 || bus.req_ready !== 1'b0) r_bad = 1'b1;
        @(negedge clk);
        r_pulse = bus.resp_valid;
    endtask
    task automatic done(input string tag);
        check({tag, "_lat"}, r_lat, 4);
        check({tag, "_stall_ready"}, r_bad, 0);
        check({tag, "_one_pulse"}, r_pulse, 0);
    endtask
    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_be = '0;
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_ready", bus.req_ready, 1);
        check("rst_stall", bus.stall, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_rdata", bus.resp_rdata, 0);
        check("rst_err", bus.resp_err, 0);
        @(negedge clk) rst = 1'b1;
        xfer(1, 32'h10, 32'hDEADBEEF, 4'hF);
        done("st_full");
        xfer(0, 32'h10, 32'h0, 4'h0);
        done("ld_full");
        check("ld_full_data", r_data, 32'hDEADBEEF);
        check("ld_full_err", r_err, 0);
        xfer(1, 32'h10, 32'h000000AA, 4'b0001);
        done("st_byte");
        check("st_byte_old", r_data, 32'hDEADBEEF);
        xfer(0, 32'h10, 32'h0, 4'h0);
        check("ld_byte_data", r_data, 32'hDEADBEAA);
        xfer(1, 32'h400, 32'h11111111, 4'hF);
        xfer(0, 32'h000, 32'h0, 4'h0);
        check("wrap_data", r_data, 32'h11111111);
        xfer(1, 32'h10, 32'h12345678, 4'h0);
        done("st_be0");
        check("st_be0_old", r_data, 32'hDEADBEAA);
        xfer(0, 32'h10, 32'h0, 4'h0);
        check("ld_be0_data", r_data, 32'hDEADBEAA);
        xfer(1, 32'h20, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'h5A5A5A5A; bus.req_be = 4'hF;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_wait", bus.stall, 1);
        rst = 1'b0;
        #1;
        check("abort_ready", bus.req_ready, 1);
        check("abort_stall", bus.stall, 0);
        flag = bus.resp_valid;
        repeat (3) begin
            @(negedge clk);
            flag = flag | bus.resp_valid;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            flag = flag | bus.resp_valid;
        end
        check("abort_no_resp", flag, 0);
        xfer(0, 32'h20, 32'h0, 4'h0);
        check("abort_prior", r_data, 32'hCAFEF00D);
        xfer(0, 32'h13, 32'h0, 4'h0);
        done("mis");
`ifdef DMEM_MISALIGN_CHECK_EN
        check("mis_err", r_err, 1);
        check("mis_data", r_data, 0);
`else
        check("mis_err", r_err, 0);
        check("mis_data", r_data, 32'hDEADBEAA);
`endif
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h10; bus.req_be = 4'h0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check($sformatf("b2b_valid_%0d", i), bus.resp_valid, (i % 5 == 4));
            check($sformatf("b2b_ready_%0d", i), bus.req_ready, (i % 5 == 0));
            check($sformatf("b2b_stall_%0d", i), bus.stall, (i % 5 != 4));
            if (i == 4) begin
                check("b2b_data0", bus.resp_rdata, 32'hDEADBEAA);
                bus.req_addr = 32'h20;
            end
            if (i == 9) begin
                check("b2b_data1", bus.resp_rdata, 32'hCAFEF00D);
                bus.req_valid = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        check("b2b_idle_ready", bus.req_ready, 1);
        check("b2b_idle_valid", bus.resp_valid, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
